// File: rtl/mmio_switch_led_pkg.sv
// rtl/mmio_switch_led_pkg.sv - shared addresses, offsets, widths and debounce state type
package mmio_switch_led_pkg;
  localparam logic [31:0] DEFAULT_LED_ADDR = 32'hFFFFFC60;
  localparam logic [31:0] DEFAULT_SW_ADDR  = 32'hFFFFFC70;

  localparam logic [31:0] OFS_LO     = 32'd0;
  localparam logic [31:0] OFS_HI     = 32'd2;
  localparam logic [31:0] OFS_STATUS = 32'd4;

  localparam int SW_W  = 19;
  localparam int LED_W = 24;

  typedef enum logic [0:0] {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;
endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - switch synchronizer, optional debounce FSM and change flag
// SWITCH_DEBOUNCE_EN selects the debounce FSM; otherwise sw_stable is the synchronizer output registered once.
module switch_debouncer
  import mmio_switch_led_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            changed_clr,
  output logic [SW_W-1:0] sw_stable,
  output logic            sw_changed
);
  logic [SW_W-1:0] sync1_q, sync2_q;
  logic [SW_W-1:0] stable_q, stable_d;
  logic            changed_q, changed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  db_state_e       state_q, state_d;
  logic [SW_W-1:0] cand_q, cand_d;
  logic [19:0]     cnt_q, cnt_d, cnt_inc;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    cnt_inc  = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
    case (state_q)
      DB_IDLE: begin
        if (sync2_q != stable_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = DB_COUNT;
        end
      end
      DB_COUNT: begin
        // Bounce back to the accepted value abandons the window without an update.
        if (sync2_q == stable_q) begin
          state_d = DB_IDLE;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEBOUNCE_CYCLES - 20'd1) begin
            stable_d = cand_q;
            state_d  = DB_IDLE;
          end
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DB_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;

  always_comb begin
    stable_d = sync2_q;
  end
`endif

  // Set takes priority over a clearing load in the same cycle.
  always_comb begin
    changed_d = (stable_d != stable_q) | (changed_q & ~changed_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign sw_stable  = stable_q;
  assign sw_changed = changed_q;
endmodule

// File: rtl/mmio_switch_led.sv
// rtl/mmio_switch_led.sv - memory-mapped LED output and debounced switch input registers
// SWITCH_DEBOUNCE_EN (see switch_debouncer) enables the debounce FSM.
module mmio_switch_led
  import mmio_switch_led_pkg::*;
#(
  parameter logic [31:0] LED_ADDR        = DEFAULT_LED_ADDR,
  parameter logic [31:0] SW_ADDR         = DEFAULT_SW_ADDR,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   switchN24,
  output logic [LED_W-1:0]  ledN24
);
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [SW_W-1:0]  sw_stable;
  logic             sw_changed;
  logic             hit_led_lo, hit_led_hi, hit_sw_lo, hit_sw_hi, hit_sw_status;
  logic             unused_wdata;

  assign unused_wdata  = ^wdata[31:16];
  assign hit_led_lo    = (addr == LED_ADDR + OFS_LO);
  assign hit_led_hi    = (addr == LED_ADDR + OFS_HI);
  assign hit_sw_lo     = (addr == SW_ADDR + OFS_LO);
  assign hit_sw_hi     = (addr == SW_ADDR + OFS_HI);
  assign hit_sw_status = (addr == SW_ADDR + OFS_STATUS);

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debouncer (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (switchN24),
    .changed_clr(mem_read & hit_sw_status),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed)
  );

  always_comb begin
    led_d = led_q;
    if (mem_write && hit_led_lo) led_d[15:0]  = wdata[15:0];
    if (mem_write && hit_led_hi) led_d[23:16] = wdata[7:0];
  end

  // Reads see register state before any same-cycle store.
  always_comb begin
    rdata_d = rdata_q;
    if (mem_read) begin
      if (hit_led_lo)         rdata_d = {16'b0, led_q[15:0]};
      else if (hit_led_hi)    rdata_d = {24'b0, led_q[23:16]};
      else if (hit_sw_lo)     rdata_d = {16'b0, sw_stable[15:0]};
      else if (hit_sw_hi)     rdata_d = {29'b0, sw_stable[18:16]};
      else if (hit_sw_status) rdata_d = {31'b0, sw_changed};
      else                    rdata_d = 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      rdata_q <= '0;
    end else begin
      led_q   <= led_d;
      rdata_q <= rdata_d;
    end
  end

  assign ledN24 = led_q;
  assign rdata  = rdata_q;
endmodule

// File: tb/tb_mmio_switch_led.sv
// tb/tb_mmio_switch_led.sv - directed self-checking bench for mmio_switch_led
module tb_mmio_switch_led;
  localparam logic [31:0] LED_A = 32'hFFFFFC60;
  localparam logic [31:0] SW_A  = 32'hFFFFFC70;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int SW_LAT = 6;
`else
  localparam int SW_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic [18:0] switchN24;
  logic [23:0] ledN24;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_switch_led #(
    .LED_ADDR       (LED_A),
    .SW_ADDR        (SW_A),
    .DEBOUNCE_CYCLES(20'd4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .switchN24(switchN24),
    .ledN24   (ledN24)
  );

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_read  = r;
    mem_write = w;
    addr      = a;
    wdata     = d;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    switchN24 = '0;
    bus(1'b1, 1'b1, LED_A, 32'hFFFFFFFF);
    checks++;
    if (ledN24 !== 24'h0) begin errors++; $display("FAIL reset_led got %h exp %h", ledN24, 24'h0); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
    rst = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_led_write;
    bus(1'b0, 1'b1, LED_A, 32'h0000A5A5);
    checks++;
    if (ledN24 !== 24'h00A5A5) begin errors++; $display("FAIL led_lo got %h exp %h", ledN24, 24'h00A5A5); end
    bus(1'b0, 1'b1, LED_A + 32'd2, 32'h0000003C);
    checks++;
    if (ledN24 !== 24'h3CA5A5) begin errors++; $display("FAIL led_hi got %h exp %h", ledN24, 24'h3CA5A5); end
    bus(1'b0, 1'b1, LED_A, 32'hFFFF1234);
    checks++;
    if (ledN24 !== 24'h3C1234) begin errors++; $display("FAIL led_lo_keep_hi got %h exp %h", ledN24, 24'h3C1234); end
    bus(1'b0, 1'b1, LED_A + 32'd2, 32'h12345678);
    checks++;
    if (ledN24 !== 24'h781234) begin errors++; $display("FAIL led_hi_keep_lo got %h exp %h", ledN24, 24'h781234); end
    bus(1'b1, 1'b0, LED_A, 32'h0);
    checks++;
    if (rdata !== 32'h00001234) begin errors++; $display("FAIL rd_led_lo got %h exp %h", rdata, 32'h00001234); end
    bus(1'b1, 1'b0, LED_A + 32'd2, 32'h0);
    checks++;
    if (rdata !== 32'h00000078) begin errors++; $display("FAIL rd_led_hi got %h exp %h", rdata, 32'h00000078); end
    bus(1'b0, 1'b0, LED_A, 32'h0);
    checks++;
    if (rdata !== 32'h00000078) begin errors++; $display("FAIL rdata_hold got %h exp %h", rdata, 32'h00000078); end
    bus(1'b0, 1'b1, SW_A, 32'h00FFFFFF);
    bus(1'b0, 1'b1, SW_A + 32'd4, 32'h00FFFFFF);
    bus(1'b0, 1'b1, LED_A + 32'd1, 32'h00FFFFFF);
    checks++;
    if (ledN24 !== 24'h781234) begin errors++; $display("FAIL unmapped_store got %h exp %h", ledN24, 24'h781234); end
    bus(1'b1, 1'b0, 32'hFFFFFC80, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rd_unmapped got %h exp %h", rdata, 32'h0); end
    bus(1'b1, 1'b0, LED_A, 32'h0);
    bus(1'b1, 1'b0, LED_A + 32'd1, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rd_led_odd got %h exp %h", rdata, 32'h0); end
  endtask

  task automatic test_read_write_same;
    bus(1'b0, 1'b1, LED_A, 32'h0);
    bus(1'b0, 1'b1, LED_A + 32'd2, 32'h0);
    bus(1'b1, 1'b1, LED_A, 32'h000000FF);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rw_same_rdata got %h exp %h", rdata, 32'h0); end
    checks++;
    if (ledN24 !== 24'h0000FF) begin errors++; $display("FAIL rw_same_led got %h exp %h", ledN24, 24'h0000FF); end
    bus(1'b1, 1'b0, LED_A, 32'h0);
    checks++;
    if (rdata !== 32'h000000FF) begin errors++; $display("FAIL rw_after got %h exp %h", rdata, 32'h000000FF); end
  endtask

  task automatic test_switch(input logic [18:0] val, input logic [31:0] rd_addr,
                             input logic [31:0] prior, input logic [31:0] expv);
    logic [31:0] e;
    switchN24 = val;
    for (int k = 1; k <= SW_LAT + 1; k++) begin
      bus(1'b1, 1'b0, rd_addr, 32'h0);
      e = (k - 1 >= SW_LAT) ? expv : prior;
      checks++;
      if (rdata !== e) begin errors++; $display("FAIL sw_latency edge %0d got %h exp %h", k, rdata, e); end
    end
  endtask

  task automatic test_changed_flag;
    bus(1'b1, 1'b0, SW_A + 32'd4, 32'h0);
    checks++;
    if (rdata !== 32'h1) begin errors++; $display("FAIL changed_set got %h exp %h", rdata, 32'h1); end
    bus(1'b1, 1'b0, SW_A + 32'd4, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL changed_clr got %h exp %h", rdata, 32'h0); end
  endtask

  task automatic test_glitch;
    switchN24 = '0;
    for (int i = 0; i < SW_LAT + 2; i++) bus(1'b0, 1'b0, 32'h0, 32'h0);
    bus(1'b1, 1'b0, SW_A + 32'd4, 32'h0);
    bus(1'b1, 1'b0, SW_A + 32'd4, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_pre_clear got %h exp %h", rdata, 32'h0); end
    switchN24 = 19'h40000;
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    switchN24 = '0;
    for (int i = 0; i < 8; i++) bus(1'b0, 1'b0, 32'h0, 32'h0);
    bus(1'b1, 1'b0, SW_A + 32'd2, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_stable got %h exp %h", rdata, 32'h0); end
    bus(1'b1, 1'b0, SW_A + 32'd4, 32'h0);
`ifdef SWITCH_DEBOUNCE_EN
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_changed got %h exp %h", rdata, 32'h0); end
`else
    checks++;
    if (rdata !== 32'h1) begin errors++; $display("FAIL glitch_changed got %h exp %h", rdata, 32'h1); end
`endif
  endtask

  task automatic test_reset_abort;
    logic [31:0] e;
    bus(1'b0, 1'b1, LED_A, 32'h0000FFFF);
    bus(1'b0, 1'b1, LED_A + 32'd2, 32'h000000FF);
    checks++;
    if (ledN24 !== 24'hFFFFFF) begin errors++; $display("FAIL abort_led_set got %h exp %h", ledN24, 24'hFFFFFF); end
    switchN24 = 19'h00055;
    bus(1'b1, 1'b0, LED_A, 32'h0);
    checks++;
    if (rdata !== 32'h0000FFFF) begin errors++; $display("FAIL abort_rdata_set got %h exp %h", rdata, 32'h0000FFFF); end
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    bus(1'b1, 1'b1, LED_A + 32'd2, 32'h00000012);
    rst = 1'b0;
    checks++;
    if (ledN24 !== 24'h0) begin errors++; $display("FAIL abort_led got %h exp %h", ledN24, 24'h0); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got %h exp %h", rdata, 32'h0); end
    for (int k = 1; k <= SW_LAT + 1; k++) begin
      bus(1'b1, 1'b0, SW_A, 32'h0);
      e = (k - 1 >= SW_LAT) ? 32'h00000055 : 32'h0;
      checks++;
      if (rdata !== e) begin errors++; $display("FAIL abort_rewindow edge %0d got %h exp %h", k, rdata, e); end
    end
    bus(1'b1, 1'b0, SW_A + 32'd4, 32'h0);
    checks++;
    if (rdata !== 32'h1) begin errors++; $display("FAIL abort_changed got %h exp %h", rdata, 32'h1); end
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    addr = '0;
    wdata = '0;
    switchN24 = '0;
    test_reset;
    test_led_write;
    test_read_write_same;
    test_switch(19'h00001, SW_A, 32'h0, 32'h00000001);
    test_changed_flag;
    test_switch(19'h7FFFF, SW_A + 32'd2, 32'h0, 32'h00000007);
    bus(1'b1, 1'b0, SW_A, 32'h0);
    checks++;
    if (rdata !== 32'h0000FFFF) begin errors++; $display("FAIL sw_lo_all got %h exp %h", rdata, 32'h0000FFFF); end
    test_glitch;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
